bf_scheduler: RTL

// Top-level sequencer for the arbitrage engine. On each start it runs NODES-1

---
 rtl/bf_scheduler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bf_scheduler.sv
// Bellman-Ford run sequencer: relax passes, then one negative-cycle scan.
// Optional BF_EARLY_EXIT_EN: stop relaxing after a pass that changed nothing.
module bf_scheduler #(
    parameter int NODES  = 32,
    parameter int IDX_W  = 5,
    parameter int PASS_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              host_req,
    output logic              host_grant,
    output logic              busy,
    output logic              run_done,
    output logic              relax_reset,
    input  logic              relax_done,
    input  logic              relax_changed,
    output logic              cycle_reset,
    input  logic              cycle_done,
    input  logic [IDX_W-1:0]  r_vaddr_a,
    input  logic [IDX_W-1:0]  r_vaddr_b,
    input  logic [IDX_W-1:0]  r_arow,
    input  logic [IDX_W-1:0]  r_acol,
    input  logic [IDX_W-1:0]  c_vaddr_a,
    input  logic [IDX_W-1:0]  c_vaddr_b,
    input  logic [IDX_W-1:0]  c_arow,
    input  logic [IDX_W-1:0]  c_acol,
    output logic [IDX_W-1:0]  vertmat_addr_a,
    output logic [IDX_W-1:0]  vertmat_addr_b,
    output logic [IDX_W-1:0]  adjmat_row_addr,
    output logic [IDX_W-1:0]  adjmat_col_addr,
    output logic [PASS_W-1:0] pass_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        RELAX_KICK,
        RELAX_WAIT,
        CYCLE_KICK,
        CYCLE_WAIT,
        FINISH
    } state_t;

    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NODES - 2);

    state_t state;
    logic   start_pend;
    logic   relax_exit;

`ifdef BF_EARLY_EXIT_EN
    assign relax_exit = (pass_cnt == LAST_PASS) || !relax_changed;
`else
    logic unused_changed;
    assign unused_changed = relax_changed;
    assign relax_exit     = (pass_cnt == LAST_PASS);
`endif

    // Engine resets default to held; only the WAIT states release them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pass_cnt    <= '0;
            start_pend  <= 1'b0;
            busy        <= 1'b0;
            run_done    <= 1'b0;
            host_grant  <= 1'b0;
            relax_reset <= 1'b1;
            cycle_reset <= 1'b1;
        end else begin
            run_done    <= 1'b0;
            host_grant  <= 1'b0;
            relax_reset <= 1'b1;
            cycle_reset <= 1'b1;
            if (start)
                start_pend <= 1'b1;
            case (state)
                IDLE: begin
                    host_grant <= host_req;
                    if ((start || start_pend) && !host_req) begin
                        state      <= RELAX_KICK;
                        pass_cnt   <= '0;
                        busy       <= 1'b1;
                        start_pend <= 1'b0;
                    end
                end
                RELAX_KICK: begin
                    state       <= RELAX_WAIT;
                    relax_reset <= 1'b0;
                end
                RELAX_WAIT: begin
                    if (relax_done) begin
                        if (relax_exit) begin
                            state <= CYCLE_KICK;
                        end else begin
                            pass_cnt <= pass_cnt + 1'b1;
                            state    <= RELAX_KICK;
                        end
                    end else begin
                        relax_reset <= 1'b0;
                    end
                end
                CYCLE_KICK: begin
                    state       <= CYCLE_WAIT;
                    cycle_reset <= 1'b0;
                end
                CYCLE_WAIT: begin
                    if (cycle_done) begin
                        state    <= FINISH;
                        run_done <= 1'b1;
                    end else begin
                        cycle_reset <= 1'b0;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        vertmat_addr_a  = '0;
        vertmat_addr_b  = '0;
        adjmat_row_addr = '0;
        adjmat_col_addr = '0;
        case (state)
            RELAX_KICK, RELAX_WAIT: begin
                vertmat_addr_a  = r_vaddr_a;
                vertmat_addr_b  = r_vaddr_b;
                adjmat_row_addr = r_arow;
                adjmat_col_addr = r_acol;
            end
            CYCLE_KICK, CYCLE_WAIT: begin
                vertmat_addr_a  = c_vaddr_a;
                vertmat_addr_b  = c_vaddr_b;
                adjmat_row_addr = c_arow;
                adjmat_col_addr = c_acol;
            end
            default: ;
        endcase
    end

endmodule
